// File: rtl/tt_bist_pkg.sv
// Shared types, constants and the golden function for the truth_table BIST.
// Optional fail-mask capture is enabled with `define TT_BIST_FAIL_MASK_EN.
package tt_bist_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} bist_state_t;

    localparam int          N_VECTORS   = 16;
    localparam logic [15:0] GOLDEN_MASK = 16'hFC55;

    // Minimal form of the stage under test: Y = A&C | A&B | ~A&~D, v = {A,B,C,D}.
    function automatic logic tt_expected(input logic [3:0] v);
        return (v[3] & v[1]) | (v[3] & v[2]) | (~v[3] & ~v[0]);
    endfunction

endpackage

// File: rtl/truth_table_bist_if.sv
// Bus between the BIST sequencer and its environment: the stage under test plus
// the host that starts a sweep and reads back the results.
interface truth_table_bist_if #(
    parameter int ERR_W = 5
);
    logic             start;
    logic             A;
    logic             B;
    logic             C;
    logic             D;
    logic             Y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       first_fail_vec;
    logic             first_fail_valid;
    logic [15:0]      fail_mask;

    modport master (
        output start, Y,
        input  A, B, C, D, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, fail_mask
    );

    modport slave (
        input  start, Y,
        output A, B, C, D, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, fail_mask
    );
endinterface

// File: rtl/tt_golden.sv
// Combinational reference: expected stage output for a 4-bit input vector.
module tt_golden
    import tt_bist_pkg::*;
(
    input  logic [3:0] vec,
    output logic       y_exp
);
    assign y_exp = tt_expected(vec);
endmodule

// File: rtl/truth_table_bist.sv
// Self-test sequencer: sweeps all 16 vectors into the truth_table stage, compares Y
// to the golden function and records errors. `define TT_BIST_FAIL_MASK_EN adds fail_mask.
module truth_table_bist
    import tt_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input logic               clk,
    input logic               reset,
    truth_table_bist_if.slave bus
);

    localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAST_VEC    = 4'(N_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    // With no settle time every vector goes straight to its compare cycle.
    localparam bist_state_t      RUN_ENTRY   = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

    bist_state_t      state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
`ifdef TT_BIST_FAIL_MASK_EN
    logic [15:0]      fail_mask_q, fail_mask_d;
`endif

    logic y_exp;
    logic mismatch;

    tt_golden u_golden (
        .vec   (vec_q),
        .y_exp (y_exp)
    );

    assign mismatch = (state_q == CHECK) && (bus.Y != y_exp);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        err_d        = err_q;
        ffv_d        = ffv_q;
        ffvalid_d    = ffvalid_q;
`ifdef TT_BIST_FAIL_MASK_EN
        fail_mask_d  = fail_mask_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    vec_d        = '0;
                    settle_cnt_d = '0;
                    err_d        = '0;
                    ffv_d        = '0;
                    ffvalid_d    = 1'b0;
`ifdef TT_BIST_FAIL_MASK_EN
                    fail_mask_d  = '0;
`endif
                    state_d      = RUN_ENTRY;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) state_d = CHECK;
                else                             settle_cnt_d = settle_cnt_q + 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
`ifdef TT_BIST_FAIL_MASK_EN
                    fail_mask_d[vec_q] = 1'b1;
`endif
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d        = vec_q + 4'd1;
                    settle_cnt_d = '0;
                    state_d      = RUN_ENTRY;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they align with it.
        busy_d = (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_cnt_q <= '0;
            err_q        <= '0;
            ffv_q        <= '0;
            ffvalid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef TT_BIST_FAIL_MASK_EN
            fail_mask_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            err_q        <= err_d;
            ffv_q        <= ffv_d;
            ffvalid_q    <= ffvalid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
`ifdef TT_BIST_FAIL_MASK_EN
            fail_mask_q  <= fail_mask_d;
`endif
        end
    end

    assign bus.A                = vec_q[3];
    assign bus.B                = vec_q[2];
    assign bus.C                = vec_q[1];
    assign bus.D                = vec_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;
`ifdef TT_BIST_FAIL_MASK_EN
    assign bus.fail_mask        = fail_mask_q;
`else
    assign bus.fail_mask        = 16'h0000;
`endif

endmodule

// File: tb/tb_truth_table_bist.sv
// Scoreboard bench for truth_table_bist: two configurations (settle 2 / 5-bit count,
// settle 0 / 3-bit count) run against a modelled stage with injectable faults.
module tb_truth_table_bist;

    localparam int S0 = 2;
    localparam int E0 = 5;
    localparam int S1 = 0;
    localparam int E1 = 3;
    // Truth table of Y = A&C | A&B | ~A&~D, bit i for vector i = {A,B,C,D}.
    localparam logic [15:0] REF_GOLDEN = 16'hFC55;

    typedef struct {
        int lat;
        int busy_cycles;
        int errs;
        int ffv;
        int ffvalid;
        int mask;
        int pass;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_edge[2];
    int busy_cnt[2];
    bit done_prev[2];
    logic [15:0] resp[2];
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    truth_table_bist_if #(.ERR_W(E0)) bus0 ();
    truth_table_bist_if #(.ERR_W(E1)) bus1 ();

    truth_table_bist #(.SETTLE_CYCLES(S0), .ERR_W(E0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    truth_table_bist #(.SETTLE_CYCLES(S1), .ERR_W(E1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Stage model: the response table is the stage's Y for each input vector.
    assign bus0.Y = resp[0][{bus0.A, bus0.B, bus0.C, bus0.D}];
    assign bus1.Y = resp[1][{bus1.A, bus1.B, bus1.C, bus1.D}];

    logic [3:0] gvec;
    logic       gy;
    tt_golden u_gold_ref (
        .vec   (gvec),
        .y_exp (gy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] r, input int settle, input int errw);
        exp_t e;
        logic [15:0] diff;
        int n;
        int cap;
        diff = r ^ REF_GOLDEN;
        cap = (1 << errw) - 1;
        n = 0;
        e.ffv = 0;
        e.ffvalid = 0;
        for (int i = 0; i < 16; i++) begin
            if (diff[i]) begin
                n++;
                if (e.ffvalid == 0) begin
                    e.ffv = i;
                    e.ffvalid = 1;
                end
            end
        end
        e.errs = (n > cap) ? cap : n;
        e.pass = (n == 0) ? 1 : 0;
        e.lat = 16 * (settle + 1);
        e.busy_cycles = 16 * (settle + 1);
`ifdef TT_BIST_FAIL_MASK_EN
        e.mask = int'(diff);
`else
        e.mask = 0;
`endif
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e, input int lat, input int bc,
                           input logic [31:0] errc, input logic [31:0] ffv,
                           input logic [31:0] ffvalid, input logic [31:0] mask,
                           input logic [31:0] pass);
        check({tag, ".latency"}, lat, e.lat);
        check({tag, ".busy_cycles"}, bc, e.busy_cycles);
        check({tag, ".err_count"}, errc, e.errs);
        check({tag, ".first_fail_vec"}, ffv, e.ffv);
        check({tag, ".first_fail_valid"}, ffvalid, e.ffvalid);
        check({tag, ".fail_mask"}, mask, e.mask);
        check({tag, ".pass"}, pass, e.pass);
    endtask

    // Monitors: compare a finished sweep whenever done rises.
    always @(negedge clk) begin
        if (reset) begin
            done_prev[0] = 1'b0;
        end else begin
            if (bus0.busy) busy_cnt[0]++;
            if (bus0.done && !done_prev[0]) begin
                if (q0.size() == 0) begin
                    check("dut0.unexpected_done", 1, 0);
                end else begin
                    e0 = q0.pop_front();
                    compare("dut0", e0, cyc - start_edge[0], busy_cnt[0], 32'(bus0.err_count),
                            32'(bus0.first_fail_vec), 32'(bus0.first_fail_valid),
                            32'(bus0.fail_mask), 32'(bus0.pass));
                end
            end
            done_prev[0] = bus0.done;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            done_prev[1] = 1'b0;
        end else begin
            if (bus1.busy) busy_cnt[1]++;
            if (bus1.done && !done_prev[1]) begin
                if (q1.size() == 0) begin
                    check("dut1.unexpected_done", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    compare("dut1", e1, cyc - start_edge[1], busy_cnt[1], 32'(bus1.err_count),
                            32'(bus1.first_fail_vec), 32'(bus1.first_fail_valid),
                            32'(bus1.fail_mask), 32'(bus1.pass));
                end
            end
            done_prev[1] = bus1.done;
        end
    end

    task automatic check_reset_vals(input int u);
        string t;
        t = $sformatf("dut%0d.rst", u);
        if (u == 0) begin
            check({t, ".abcd"}, 32'({bus0.A, bus0.B, bus0.C, bus0.D}), 0);
            check({t, ".busy"}, 32'(bus0.busy), 0);
            check({t, ".done"}, 32'(bus0.done), 0);
            check({t, ".pass"}, 32'(bus0.pass), 0);
            check({t, ".err_count"}, 32'(bus0.err_count), 0);
            check({t, ".first_fail_vec"}, 32'(bus0.first_fail_vec), 0);
            check({t, ".first_fail_valid"}, 32'(bus0.first_fail_valid), 0);
            check({t, ".fail_mask"}, 32'(bus0.fail_mask), 0);
        end else begin
            check({t, ".abcd"}, 32'({bus1.A, bus1.B, bus1.C, bus1.D}), 0);
            check({t, ".busy"}, 32'(bus1.busy), 0);
            check({t, ".done"}, 32'(bus1.done), 0);
            check({t, ".err_count"}, 32'(bus1.err_count), 0);
        end
    endtask

    task automatic issue_start(input int u, input bit run);
        @(posedge clk);
        #1;
        if (u == 0) bus0.start = 1'b1;
        else        bus1.start = 1'b1;
        if (run) begin
            if (u == 0) q0.push_back(model(resp[0], S0, E0));
            else        q1.push_back(model(resp[1], S1, E1));
            start_edge[u] = cyc + 1;
            busy_cnt[u] = 0;
        end
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        if (run) begin
            if (u == 0) begin
                check("dut0.start.busy", 32'(bus0.busy), 1);
                check("dut0.start.done", 32'(bus0.done), 0);
                check("dut0.start.err_cleared", 32'(bus0.err_count), 0);
                check("dut0.start.ffvalid_cleared", 32'(bus0.first_fail_valid), 0);
                check("dut0.start.abcd", 32'({bus0.A, bus0.B, bus0.C, bus0.D}), 0);
            end else begin
                check("dut1.start.busy", 32'(bus1.busy), 1);
                check("dut1.start.done", 32'(bus1.done), 0);
                check("dut1.start.err_cleared", 32'(bus1.err_count), 0);
                check("dut1.start.mask_cleared", 32'(bus1.fail_mask), 0);
            end
        end
    endtask

    task automatic wait_done(input int u, input int budget);
        int n;
        n = 0;
        while (((u == 0) ? bus0.done : bus1.done) !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("dut%0d.done_within_budget", u), 32'(n < budget), 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] gold_bits;
        reset = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        resp[0] = REF_GOLDEN;
        resp[1] = REF_GOLDEN;

        // Reference sub-module against the table.
        gold_bits = REF_GOLDEN;
        for (int i = 0; i < 16; i++) begin
            gvec = 4'(i);
            #1;
            check($sformatf("tt_golden.vec%0d", i), 32'(gy), 32'(gold_bits[i]));
        end

        // Reset, with start coincident on the last reset cycle: reset wins.
        repeat (3) @(posedge clk);
        #1;
        bus0.start = 1'b1;
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        check_reset_vals(0);
        check_reset_vals(1);
        @(posedge clk);
        #1;
        check("dut0.idle_after_reset.busy", 32'(bus0.busy), 0);

        // Healthy stage.
        issue_start(0, 1);
        wait_done(0, 200);

        // Stuck-at-0 with ignored start pulses mid-sweep.
        resp[0] = 16'h0000;
        issue_start(0, 1);
        repeat (5) @(posedge clk);
        issue_start(0, 0);
        repeat (10) @(posedge clk);
        issue_start(0, 0);
        issue_start(0, 0);
        wait_done(0, 200);
        repeat (3) @(posedge clk);
        #1;
        check("dut0.done_held", 32'(bus0.done), 1);
        check("dut0.err_held", 32'(bus0.err_count), 10);

        // Stuck-at-1, started from DONE.
        resp[0] = 16'hFFFF;
        issue_start(0, 1);
        wait_done(0, 200);

        // Random fault patterns.
        for (int k = 0; k < 4; k++) begin
            resp[0] = REF_GOLDEN ^ ((k == 0) ? 16'h0000 : 16'($urandom));
            issue_start(0, 1);
            wait_done(0, 200);
        end

        // Reset mid-sweep while vector 7 is settling.
        resp[0] = REF_GOLDEN;
        issue_start(0, 1);
        n = 0;
        while (!({bus0.A, bus0.B, bus0.C, bus0.D} == 4'd7 && bus0.busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("dut0.reached_vec7", 32'(n < 200), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        check_reset_vals(0);
        issue_start(0, 1);
        wait_done(0, 200);

        // Zero-settle, 3-bit saturating counter.
        resp[1] = ~REF_GOLDEN;
        issue_start(1, 1);
        wait_done(1, 100);
        resp[1] = 16'h0000;
        issue_start(1, 1);
        wait_done(1, 100);
        resp[1] = 16'hFFFF;
        issue_start(1, 1);
        wait_done(1, 100);
        resp[1] = REF_GOLDEN ^ 16'($urandom);
        issue_start(1, 1);
        wait_done(1, 100);

        check("dut0.scoreboard_drained", 32'(q0.size()), 0);
        check("dut1.scoreboard_drained", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
